alu_op_sequencer: RTL and testbench

- Multi-cycle controller in front of the combinational ALU; accepts one operation at a time over a valid/ready request channel.
- Registers the operands and drives the ALU inputs stably for an opcode-dependent number of cycles, so mul/div get a multi-cycle path.
- Captures the 64-bit ALU result into hi/lo response registers and returns it over a valid/ready response channel.

---
 rtl/alu_op_sequencer_if.sv | 49 ++++
 rtl/alu_op_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle for alu_op_sequencer.
// Carries rsp_div0 only when ALU_DIV0_TRAP_EN is defined.
interface alu_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_illegal;
`ifdef ALU_DIV0_TRAP_EN
    logic        rsp_div0;
`endif

    modport master (
`ifdef ALU_DIV0_TRAP_EN
        input  rsp_div0,
`endif
        output req_valid,
        output req_opcode,
        output req_a,
        output req_b,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_lo,
        input  rsp_hi,
        input  rsp_illegal
    );

    modport slave (
`ifdef ALU_DIV0_TRAP_EN
        output rsp_div0,
`endif
        input  req_valid,
        input  req_opcode,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_lo,
        output rsp_hi,
        output rsp_illegal
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer holding ALU operands for an opcode-dependent latency.
// Optional divide-by-zero trap enabled by defining ALU_DIV0_TRAP_EN.
module alu_op_sequencer #(
    parameter int unsigned SIMPLE_CYCLES = 1,
    parameter int unsigned MUL_CYCLES    = 4,
    parameter int unsigned DIV_CYCLES    = 8
) (
    input  logic               clk,
    input  logic               clr_n,
    alu_op_sequencer_if.slave  bus,
    output logic [4:0]         alu_opcode,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    input  logic [63:0]        alu_result,
    output logic               busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SAR  = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // Counter is loaded with latency-1 so it reaches 0 on the capture edge
    localparam logic [7:0] LAT_SIMPLE = 8'(SIMPLE_CYCLES - 1);
    localparam logic [7:0] LAT_MUL    = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] LAT_DIV    = 8'(DIV_CYCLES - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        ill_q;
    logic        div0_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic        illegal_q;

    logic        req_legal;
    logic        div0_hit;
    logic [7:0]  lat_m1;

    always_comb begin
        req_legal = 1'b0;
        unique case (bus.req_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SAR, OP_SHL, OP_ROR,
            OP_ROL, OP_ANDI, OP_ORI, OP_MUL,
            OP_DIV, OP_NEG, OP_NOT: req_legal = 1'b1;
            default:                req_legal = 1'b0;
        endcase
    end

    always_comb begin
        lat_m1   = 8'd0;
        div0_hit = 1'b0;
        unique case (1'b1)
            !req_legal:                 lat_m1 = 8'd0;
            bus.req_opcode == OP_MUL:   lat_m1 = LAT_MUL;
            bus.req_opcode == OP_DIV:   lat_m1 = LAT_DIV;
            default:                    lat_m1 = LAT_SIMPLE;
        endcase
`ifdef ALU_DIV0_TRAP_EN
        // Divide by zero short-circuits the divider entirely
        if (bus.req_opcode == OP_DIV && bus.req_b == 32'd0) begin
            lat_m1   = 8'd0;
            div0_hit = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            ill_q      <= 1'b0;
            div0_q     <= 1'b0;
            alu_opcode <= 5'd0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            lo_q       <= 32'd0;
            hi_q       <= 32'd0;
            illegal_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        alu_opcode <= bus.req_opcode;
                        alu_a      <= bus.req_a;
                        alu_b      <= bus.req_b;
                        cnt        <= lat_m1;
                        ill_q      <= !req_legal;
                        div0_q     <= div0_hit;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt == 8'd0) begin
                        if (ill_q || div0_q) begin
                            lo_q <= 32'd0;
                            hi_q <= 32'd0;
                        end else begin
                            lo_q <= alu_result[31:0];
                            hi_q <= alu_result[63:32];
                        end
                        illegal_q <= ill_q;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_DIV0_TRAP_EN
    logic div0_rsp_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            div0_rsp_q <= 1'b0;
        end else if (state == S_EXEC && cnt == 8'd0) begin
            div0_rsp_q <= div0_q;
        end
    end

    assign bus.rsp_div0 = div0_rsp_q;
`endif

    assign bus.req_ready   = (state == S_IDLE);
    assign bus.rsp_valid   = (state == S_RESP);
    assign bus.rsp_lo      = lo_q;
    assign bus.rsp_hi      = hi_q;
    assign bus.rsp_illegal = illegal_q;
    assign busy            = (state != S_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU model.
// Div-by-zero checks follow ALU_DIV0_TRAP_EN.
module tb_alu_op_sequencer;

    logic        clk;
    logic        clr_n;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [63:0] alu_result;
    logic        busy;

    int n_run;
    int n_fail;

    alu_op_sequencer_if bus ();

    alu_op_sequencer dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .bus        (bus.slave),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: garbage on unknown codes so forced zeros are visible
    always_comb begin
        alu_result = 64'hDEAD_BEEF_DEAD_BEEF;
        case (alu_opcode)
            5'b00011: alu_result = {32'd0, alu_a + alu_b};
            5'b00100: alu_result = {32'd0, alu_a - alu_b};
            5'b00101: alu_result = {32'd0, alu_a & alu_b};
            5'b00110: alu_result = {32'd0, alu_a | alu_b};
            5'b00111: alu_result = {32'd0, alu_a >> alu_b[4:0]};
            5'b01000: alu_result = {32'd0, $signed(alu_a) >>> alu_b[4:0]};
            5'b01001: alu_result = {32'd0, alu_a << alu_b[4:0]};
            5'b01010: alu_result = {32'd0, (alu_a >> alu_b[4:0]) | (alu_a << (6'd32 - {1'b0, alu_b[4:0]}))};
            5'b01011: alu_result = {32'd0, (alu_a << alu_b[4:0]) | (alu_a >> (6'd32 - {1'b0, alu_b[4:0]}))};
            5'b01101: alu_result = {32'd0, alu_a & alu_b};
            5'b01110: alu_result = {32'd0, alu_a | alu_b};
            5'b01111: alu_result = {32'd0, alu_a} * {32'd0, alu_b};
            5'b10000: alu_result = (alu_b == 32'd0) ? {alu_a, 32'hFFFF_FFFF}
                                                    : {alu_a % alu_b, alu_a / alu_b};
            5'b10001: alu_result = {32'd0, 32'd0 - alu_a};
            5'b10010: alu_result = {32'd0, ~alu_a};
            default: ;
        endcase
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        ill;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, got, exp);
        end
    endtask

    task automatic do_op(input string nm, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input logic exp_ill);
        int k;
        int lat;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_a      = a;
        bus.req_b      = b;
        k = 0;
        while (!bus.req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " accept"}, 64'(k < 200), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 300) begin
            chk({nm, " hold ab"}, {alu_a, alu_b}, {a, b});
            chk({nm, " hold op/busy/rdy"}, 64'({alu_opcode, busy, bus.req_ready}),
                64'({op, 1'b1, 1'b0}));
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, " lo"}, 64'(bus.rsp_lo), 64'(exp_lo));
        chk({nm, " hi"}, 64'(bus.rsp_hi), 64'(exp_hi));
        chk({nm, " illegal"}, 64'(bus.rsp_illegal), 64'(exp_ill));
    endtask

    task automatic ack(input string nm);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk({nm, " ack valid"}, 64'({bus.rsp_valid, bus.req_ready}), 64'({1'b0, 1'b1}));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_run  = 0;
        n_fail = 0;
        vecs[0]  = '{5'b00011, 32'd5,          32'd7,          1, 32'd12,         32'd0, 1'b0};
        vecs[1]  = '{5'b00100, 32'd5,          32'd7,          1, 32'hFFFF_FFFE,  32'd0, 1'b0};
        vecs[2]  = '{5'b00101, 32'h0000_F0F0,  32'h0000_FF00,  1, 32'h0000_F000,  32'd0, 1'b0};
        vecs[3]  = '{5'b00110, 32'h0000_F0F0,  32'h0000_0F0F,  1, 32'h0000_FFFF,  32'd0, 1'b0};
        vecs[4]  = '{5'b00111, 32'h8000_0000,  32'd4,          1, 32'h0800_0000,  32'd0, 1'b0};
        vecs[5]  = '{5'b01000, 32'h8000_0000,  32'd4,          1, 32'hF800_0000,  32'd0, 1'b0};
        vecs[6]  = '{5'b01001, 32'd1,          32'd31,         1, 32'h8000_0000,  32'd0, 1'b0};
        vecs[7]  = '{5'b01010, 32'd1,          32'd1,          1, 32'h8000_0000,  32'd0, 1'b0};
        vecs[8]  = '{5'b01011, 32'h8000_0001,  32'd4,          1, 32'h0000_0018,  32'd0, 1'b0};
        vecs[9]  = '{5'b01110, 32'h0000_00A0,  32'h0000_0005,  1, 32'h0000_00A5,  32'd0, 1'b0};
        vecs[10] = '{5'b01111, 32'h0001_0000,  32'h0001_0000,  4, 32'd0,          32'd1, 1'b0};
        vecs[11] = '{5'b01111, 32'hFFFF_FFFF,  32'd2,          4, 32'hFFFF_FFFE,  32'd1, 1'b0};
        vecs[12] = '{5'b10001, 32'd1,          32'd0,          1, 32'hFFFF_FFFF,  32'd0, 1'b0};
        vecs[13] = '{5'b10010, 32'd0,          32'd0,          1, 32'hFFFF_FFFF,  32'd0, 1'b0};
        vecs[14] = '{5'b10011, 32'd1,          32'd1,          1, 32'd0,          32'd0, 1'b1};
        vecs[15] = '{5'b11111, 32'd1,          32'd1,          1, 32'd0,          32'd0, 1'b1};
        vecs[16] = '{5'b10000, 32'd100,        32'd7,          8, 32'd14,         32'd2, 1'b0};

        bus.req_valid  = 1'b0;
        bus.req_opcode = 5'd0;
        bus.req_a      = 32'd0;
        bus.req_b      = 32'd0;
        bus.rsp_ready  = 1'b0;
        clr_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready/valid/busy", 64'({bus.req_ready, bus.rsp_valid, busy}),
            64'({1'b1, 1'b0, 1'b0}));
        chk("reset rsp lo/hi", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
        chk("reset alu ab", {alu_a, alu_b}, 64'd0);
        chk("reset alu op/illegal", 64'({alu_opcode, bus.rsp_illegal}), 64'd0);
`ifdef ALU_DIV0_TRAP_EN
        chk("reset div0", 64'(bus.rsp_div0), 64'd0);
`endif
        @(negedge clk);
        clr_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].lat, vecs[i].lo, vecs[i].hi, vecs[i].ill);
            ack($sformatf("vec%0d", i));
        end

        // Back-pressure: response must stay put while a new request waits
        do_op("bp div", 5'b10000, 32'd17, 32'd5, 8, 32'd3, 32'd2, 1'b0);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_opcode = 5'b00011;
        bus.req_a      = 32'd10;
        bus.req_b      = 32'd20;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp held rsp", {bus.rsp_hi, bus.rsp_lo}, {32'd2, 32'd3});
            chk("bp valid/ready", 64'({bus.rsp_valid, bus.req_ready}), 64'({1'b1, 1'b0}));
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("bp after hs", 64'({bus.rsp_valid, bus.req_ready, busy}), 64'({1'b0, 1'b1, 1'b0}));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("bp next accepted", 64'({busy, alu_opcode}), 64'({1'b1, 5'b00011}));
        @(posedge clk);
        #1;
        chk("bp next rsp", 64'({bus.rsp_valid, bus.rsp_lo}), 64'({1'b1, 32'd30}));
        ack("bp next");

        // Reset in the third EXEC cycle of a divide
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_opcode = 5'b10000;
        bus.req_a      = 32'd17;
        bus.req_b      = 32'd5;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst pre busy", 64'(busy), 64'd1);
        clr_n = 1'b0;
        #1;
        chk("rst mid valid/busy", 64'({bus.rsp_valid, busy, bus.req_ready}),
            64'({1'b0, 1'b0, 1'b1}));
        chk("rst mid alu ab", {alu_a, alu_b}, 64'd0);
        chk("rst mid rsp", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
        @(negedge clk);
        clr_n = 1'b1;
        do_op("post rst add", 5'b00011, 32'd2, 32'd3, 1, 32'd5, 32'd0, 1'b0);
        ack("post rst add");

`ifdef ALU_DIV0_TRAP_EN
        do_op("div0 trap", 5'b10000, 32'd9, 32'd0, 1, 32'd0, 32'd0, 1'b0);
        chk("div0 flag", 64'(bus.rsp_div0), 64'd1);
        ack("div0 trap");
        do_op("div after trap", 5'b10000, 32'd9, 32'd3, 8, 32'd3, 32'd0, 1'b0);
        chk("div0 cleared", 64'(bus.rsp_div0), 64'd0);
        ack("div after trap");
`else
        do_op("div0 raw", 5'b10000, 32'd9, 32'd0, 8, 32'hFFFF_FFFF, 32'd9, 1'b0);
        ack("div0 raw");
        do_op("div after raw", 5'b10000, 32'd9, 32'd3, 8, 32'd3, 32'd0, 1'b0);
        ack("div after raw");
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
